// File: rtl/serial_divider_pkg.sv
// rtl/serial_divider_pkg.sv - shared divider/multiplier constants and FSM encoding
package serial_divider_pkg;

    localparam int MAX_PRECISION_DEFAULT = 16;

    // Top bits of this seed give the most-negative value for any width up to 64.
    localparam logic [63:0] MIN_SEED = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/restoring_div_step.sv
// rtl/restoring_div_step.sv - one combinational restoring-division shift/compare/subtract step
module restoring_div_step #(
    parameter int W = 16
) (
    input  logic [W-1:0] rem_in,
    input  logic         bit_in,
    input  logic [W-1:0] dvs,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);

    // One extra bit so the shifted remainder can exceed the largest divisor magnitude.
    logic [W:0] shifted;
    logic [W:0] diff;

    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {1'b0, dvs};
        q_bit   = (shifted >= {1'b0, dvs});
        rem_out = q_bit ? diff[W-1:0] : shifted[W-1:0];
    end

endmodule

// File: rtl/serial_divider.sv
// rtl/serial_divider.sv - signed restoring serial divider, one quotient bit per clock
module serial_divider
    import serial_divider_pkg::*;
#(
    parameter int MAX_PRECISION = MAX_PRECISION_DEFAULT
) (
    input  logic                     clk_gate,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [MAX_PRECISION-1:0] dividend,
    input  logic [MAX_PRECISION-1:0] divisor,
    output logic [MAX_PRECISION-1:0] quotient,
    output logic [MAX_PRECISION-1:0] remainder,
    output logic                     div_by_zero,
    output logic                     overflow,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int W  = MAX_PRECISION;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [W-1:0] MIN_W = MIN_SEED[63 -: W];

    div_state_t    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  dq_q, dq_d;          // dividend magnitude shifts out as quotient shifts in
    logic [W-1:0]  dvs_q, dvs_d;
    logic [W-1:0]  rem_q, rem_d;
    logic          dvd_neg_q, dvd_neg_d;
    logic          dvs_neg_q, dvs_neg_d;
    logic [W-1:0]  quotient_q, quotient_d;
    logic [W-1:0]  remainder_q, remainder_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;

    logic [W-1:0]  dividend_abs, divisor_abs;
    logic [W-1:0]  step_rem, q_next;
    logic          step_bit;

    restoring_div_step #(.W(W)) u_step (
        .rem_in  (rem_q),
        .bit_in  (dq_q[W-1]),
        .dvs     (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    always_comb begin
        dividend_abs = dividend[W-1] ? -dividend : dividend;
        divisor_abs  = divisor[W-1]  ? -divisor  : divisor;
        q_next       = {dq_q[W-2:0], step_bit};

        state_d     = state_q;
        count_d     = count_q;
        dq_d        = dq_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        dvd_neg_d   = dvd_neg_q;
        dvs_neg_d   = dvs_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    dbz_d     = 1'b0;
                    ovf_d     = 1'b0;
                    dvd_neg_d = dividend[W-1];
                    dvs_neg_d = divisor[W-1];
                    dq_d      = dividend_abs;
                    dvs_d     = divisor_abs;
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = ST_DONE;
                    end else if (dividend == MIN_W && divisor == '1) begin
                        quotient_d  = MIN_W;
                        remainder_d = '0;
                        ovf_d       = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        count_d = CW'(W - 1);
                        rem_d   = '0;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                dq_d  = q_next;
                rem_d = step_rem;
                if (count_q == '0) begin
                    quotient_d  = (dvd_neg_q ^ dvs_neg_q) ? -q_next : q_next;
                    remainder_d = dvd_neg_q ? -step_rem : step_rem;
                    state_d     = ST_DONE;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_gate or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            dq_q        <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            dvd_neg_q   <= 1'b0;
            dvs_neg_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            dq_q        <= dq_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            dvd_neg_q   <= dvd_neg_d;
            dvs_neg_q   <= dvs_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_serial_divider.sv
// tb/tb_serial_divider.sv - self-checking bench for serial_divider
module tb_serial_divider;

    localparam int W = 16;

    logic         clk_gate = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;
    logic         out_valid;
    logic         out_ready;

    int tests = 0;
    int fails = 0;

    always #5 clk_gate = ~clk_gate;

    serial_divider #(.MAX_PRECISION(W)) dut (
        .clk_gate    (clk_gate),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        bit dbz;
        bit ovf;
        int lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer division truncates toward zero with remainder taking the dividend's sign.
    task automatic ref_div(input int a, input int b, output int q, output int r,
                           output bit dbz, output bit ovf, output int lat);
        dbz = 1'b0;
        ovf = 1'b0;
        lat = W + 1;
        if (b == 0) begin
            q = -1; r = a; dbz = 1'b1; lat = 1;
        end else if (a == -(1 << (W - 1)) && b == -1) begin
            q = a; r = 0; ovf = 1'b1; lat = 1;
        end else begin
            q = a / b; r = a % b;
        end
    endtask

    task automatic run_div(input string name, input int a, input int b, input int q, input int r,
                           input bit dbz, input bit ovf, input int lat);
        int edges;
        int waitc;
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            @(negedge clk_gate);
            waitc++;
        end
        check({name, " in_ready"}, int'(in_ready), 1);
        dividend = a[W-1:0];
        divisor  = b[W-1:0];
        in_valid = 1'b1;
        @(posedge clk_gate);
        edges = 1;
        @(negedge clk_gate);
        in_valid = 1'b0;
        while (!out_valid && edges < 100) begin
            @(posedge clk_gate);
            edges++;
            @(negedge clk_gate);
        end
        check({name, " latency"},   edges, lat);
        check({name, " out_valid"}, int'(out_valid), 1);
        check({name, " quotient"},  int'($signed(quotient)), q);
        check({name, " remainder"}, int'($signed(remainder)), r);
        check({name, " dbz"},       int'(div_by_zero), int'(dbz));
        check({name, " ovf"},       int'(overflow), int'(ovf));
        out_ready = 1'b1;
        @(posedge clk_gate);
        @(negedge clk_gate);
        out_ready = 1'b0;
        check({name, " back idle"}, int'(in_ready && !out_valid), 1);
    endtask

    initial begin
        int q, r, lat, a, b, sel;
        bit dbz, ovf;
        logic [W-1:0] ra, rb;
        logic [W-1:0] hold_q, hold_r;

        vecs[0]  = '{100,    7,   14,     2,  1'b0, 1'b0, 17};
        vecs[1]  = '{-100,   7,   -14,    -2, 1'b0, 1'b0, 17};
        vecs[2]  = '{100,    -7,  -14,    2,  1'b0, 1'b0, 17};
        vecs[3]  = '{-100,   -7,  14,     -2, 1'b0, 1'b0, 17};
        vecs[4]  = '{5,      0,   -1,     5,  1'b1, 1'b0, 1};
        vecs[5]  = '{-32768, -1,  -32768, 0,  1'b0, 1'b1, 1};
        vecs[6]  = '{32767,  1,   32767,  0,  1'b0, 1'b0, 17};
        vecs[7]  = '{3,      10,  0,      3,  1'b0, 1'b0, 17};
        vecs[8]  = '{-3,     10,  0,      -3, 1'b0, 1'b0, 17};
        vecs[9]  = '{-32768, 1,   -32768, 0,  1'b0, 1'b0, 17};
        vecs[10] = '{-32768, 0,   -1,     -32768, 1'b1, 1'b0, 1};
        vecs[11] = '{32767,  -32768, 0,   32767, 1'b0, 1'b0, 17};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk_gate);
        check("reset quotient",  int'(quotient), 0);
        check("reset remainder", int'(remainder), 0);
        check("reset flags",     int'({div_by_zero, overflow}), 0);
        check("reset out_valid", int'(out_valid), 0);
        rst_n = 1'b1;
        @(negedge clk_gate);
        check("post reset in_ready", int'(in_ready), 1);

        for (int i = 0; i < 12; i++) begin
            run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                    vecs[i].dbz, vecs[i].ovf, vecs[i].lat);
        end

        // Result held while consumer stalls; new operands offered meanwhile must be ignored.
        dividend = 16'd1000;
        divisor  = 16'd3;
        in_valid = 1'b1;
        @(posedge clk_gate);
        @(negedge clk_gate);
        in_valid = 1'b0;
        check("stall in_ready calc", int'(in_ready), 0);
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk_gate);
        check("stall q", int'($signed(quotient)), 333);
        check("stall r", int'($signed(remainder)), 1);
        hold_q   = quotient;
        hold_r   = remainder;
        dividend = 16'd77;
        divisor  = 16'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_gate);
            check("stall hold q",     int'(quotient), int'(hold_q));
            check("stall hold r",     int'(remainder), int'(hold_r));
            check("stall out_valid",  int'(out_valid), 1);
            check("stall in_ready",   int'(in_ready), 0);
            check("stall dbz",        int'(div_by_zero), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk_gate);
        @(negedge clk_gate);
        out_ready = 1'b0;
        check("stall release out_valid", int'(out_valid), 0);
        check("stall release in_ready",  int'(in_ready), 1);

        // Asynchronous reset in the middle of a calculation.
        dividend = 16'd1234;
        divisor  = 16'd5;
        in_valid = 1'b1;
        @(posedge clk_gate);
        @(negedge clk_gate);
        in_valid = 1'b0;
        repeat (7) @(negedge clk_gate);
        rst_n = 1'b0;
        #1;
        check("midreset quotient",  int'(quotient), 0);
        check("midreset remainder", int'(remainder), 0);
        check("midreset out_valid", int'(out_valid), 0);
        check("midreset flags",     int'({div_by_zero, overflow}), 0);
        @(negedge clk_gate);
        rst_n = 1'b1;
        @(negedge clk_gate);
        check("midreset in_ready", int'(in_ready), 1);
        run_div("after reset", 9, 3, 3, 0, 1'b0, 1'b0, 17);

        for (int n = 0; n < 150; n++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            sel = int'($urandom_range(0, 9));
            a   = int'($signed(ra));
            b   = int'($signed(rb));
            if (sel == 0) b = 0;
            else if (sel == 1) begin a = -32768; b = -1; end
            else if (sel < 5) b = int'($urandom_range(1, 40)) * ((rb[0]) ? -1 : 1);
            ref_div(a, b, q, r, dbz, ovf, lat);
            run_div($sformatf("rand%0d %0d/%0d", n, a, b), a, b, q, r, dbz, ovf, lat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
